// File: rtl/xdata_arbiter.sv
// Arbitrates one single-port xdata RAM between the r8051 CPU xdata port and a byte-wide DMA requester.
// Optional DMA write protection above PROT_BASE is enabled with `define XDATA_WR_PROTECT_EN.
module xdata_arbiter #(
  parameter int                 ADDR_W     = 16,
  parameter int                 STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0]  PROT_BASE  = 'h0070
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_en,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [7:0]        cpu_wr_byte,
  output logic [7:0]        cpu_rd_byte,
  output logic              cpu_rd_vld,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_gnt,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvld,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic {IDLE, CPU_PEND} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef XDATA_WR_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  state_t            state;
  owner_t            rd_owner;
  logic [ADDR_W-1:0] pend_addr;
  logic [3:0]        starve_cnt;
  logic [7:0]        cpu_hold;
  logic [7:0]        dma_hold;

  logic              rd_want;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              starved;
  logic              dma_blocked;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_want     = (state == CPU_PEND) || cpu_rd_en;
    rd_addr     = (state == CPU_PEND) ? pend_addr : cpu_rd_addr;
    starved     = dma_req && (starve_cnt == STARVE_LIM);
    dma_blocked = PROT_EN && dma_we && (dma_addr >= PROT_BASE);
    rd_issue    = 1'b0;
    dma_gnt     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 8'h00;
    // Nothing reaches the RAM while reset is held, whatever the requesters drive.
    if (rst_n) begin
      if (cpu_wr_en) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_wr_addr;
        mem_wdata = cpu_wr_byte;
      end else if (rd_want && !starved) begin
        rd_issue  = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = rd_addr;
      end else if (dma_req) begin
        dma_gnt   = 1'b1;
        mem_en    = !dma_blocked;
        mem_we    = dma_we && !dma_blocked;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_owner   <= OWN_NONE;
      pend_addr  <= '0;
      starve_cnt <= 4'd0;
      cpu_hold   <= 8'h00;
      dma_hold   <= 8'h00;
    end else begin
      case (state)
        IDLE: if (cpu_rd_en && !rd_issue) begin
          pend_addr <= cpu_rd_addr;
          state     <= CPU_PEND;
        end
        CPU_PEND: if (rd_issue) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (rd_issue)              rd_owner <= OWN_CPU;
      else if (dma_gnt && !dma_we) rd_owner <= OWN_DMA;
      else                       rd_owner <= OWN_NONE;

      // Returned bytes are kept so both read ports hold their last value.
      if (rd_owner == OWN_CPU) cpu_hold <= mem_rdata;
      if (rd_owner == OWN_DMA) dma_hold <= mem_rdata;

      if (dma_req && !dma_gnt) begin
        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= 4'd0;
      end
    end
  end

`ifdef XDATA_WR_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   dma_err <= 1'b0;
    else if (dma_gnt && dma_blocked) dma_err <= 1'b1;
  end
`else
  assign dma_err = 1'b0;
`endif

  assign cpu_rd_vld  = (state == IDLE);
  assign cpu_rd_byte = (rd_owner == OWN_CPU) ? mem_rdata : cpu_hold;
  assign dma_rvld    = (rd_owner == OWN_DMA);
  assign dma_rdata   = (rd_owner == OWN_DMA) ? mem_rdata : dma_hold;

endmodule

// File: tb/tb_xdata_arbiter.sv
// Self-checking bench for xdata_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules and a shadow memory.
module tb_xdata_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd_en, cpu_wr_en, dma_req, dma_we;
  logic [15:0] cpu_rd_addr, cpu_wr_addr, dma_addr;
  logic [7:0]  cpu_wr_byte, dma_wdata;
  logic [7:0]  cpu_rd_byte, dma_rdata;
  logic        cpu_rd_vld, dma_gnt, dma_rvld, dma_err;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  tb_mem [0:511];

  int n_checks = 0;
  int n_fail   = 0;

  xdata_arbiter #(.ADDR_W(16), .STARVE_MAX(STARVE_MAX), .PROT_BASE(16'h0070)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_byte(cpu_wr_byte),
    .cpu_rd_byte(cpu_rd_byte), .cpu_rd_vld(cpu_rd_vld),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvld(dma_rvld), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_addr[8:0]] <= pl_data;
    else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[8:0]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[8:0]];
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_rd_en = 0; cpu_wr_en = 0; dma_req = 0; dma_we = 0;
    cpu_rd_addr = '0; cpu_wr_addr = '0; dma_addr = '0; cpu_wr_byte = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if ({mem_en, mem_we, dma_gnt, dma_rvld, dma_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: en/we/gnt/rvld/err=%b want 00000", {mem_en, mem_we, dma_gnt, dma_rvld, dma_err}); end
    n_checks++; if (cpu_rd_vld !== 1'b1) begin n_fail++; $display("FAIL reset_vld: got %b want 1", cpu_rd_vld); end
    n_checks++; if ({cpu_rd_byte, dma_rdata} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: cpu=%h dma=%h want 00 00", cpu_rd_byte, dma_rdata); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    preload(16'h0010, 8'hA5);
    cpu_rd_en = 1; cpu_rd_addr = 16'h0010;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0010}) begin
      n_fail++; $display("FAIL cpu_rd_issue: en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr); end
    n_checks++; if (cpu_rd_vld !== 1'b1) begin n_fail++; $display("FAIL cpu_rd_vld0: got %b want 1", cpu_rd_vld); end
    @(negedge clk); cpu_rd_en = 0;
    #1;
    n_checks++; if ({cpu_rd_vld, cpu_rd_byte} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL cpu_rd_data: vld=%b byte=%h want 1 a5", cpu_rd_vld, cpu_rd_byte); end
    @(negedge clk); #1;
    n_checks++; if ({cpu_rd_vld, cpu_rd_byte} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL cpu_rd_hold: vld=%b byte=%h want 1 a5", cpu_rd_vld, cpu_rd_byte); end
    @(negedge clk);
  endtask

  task automatic test_wr_rd_collision();
    preload(16'h0020, 8'h00);
    cpu_wr_en = 1; cpu_wr_addr = 16'h0020; cpu_wr_byte = 8'h3C;
    cpu_rd_en = 1; cpu_rd_addr = 16'h0020;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_rd_vld} !== {2'b11, 16'h0020, 8'h3C, 1'b1}) begin
      n_fail++; $display("FAIL coll_write: en=%b we=%b addr=%h wd=%h vld=%b want 1 1 0020 3c 1",
                         mem_en, mem_we, mem_addr, mem_wdata, cpu_rd_vld); end
    @(negedge clk); cpu_wr_en = 0;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_addr, cpu_rd_vld} !== {2'b10, 16'h0020, 1'b0}) begin
      n_fail++; $display("FAIL coll_defer: en=%b we=%b addr=%h vld=%b want 1 0 0020 0", mem_en, mem_we, mem_addr, cpu_rd_vld); end
    @(negedge clk); cpu_rd_en = 0;
    #1;
    n_checks++; if ({cpu_rd_vld, cpu_rd_byte} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL coll_return: vld=%b byte=%h want 1 3c", cpu_rd_vld, cpu_rd_byte); end
    @(negedge clk);
  endtask

  task automatic test_dma_read();
    preload(16'h0005, 8'h77);
    dma_req = 1; dma_we = 0; dma_addr = 16'h0005;
    #1;
    n_checks++; if ({dma_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 16'h0005}) begin
      n_fail++; $display("FAIL dma_rd_issue: gnt=%b en=%b we=%b addr=%h want 1 1 0 0005", dma_gnt, mem_en, mem_we, mem_addr); end
    @(negedge clk); dma_req = 0;
    #1;
    n_checks++; if ({dma_rvld, dma_rdata, dma_gnt} !== {1'b1, 8'h77, 1'b0}) begin
      n_fail++; $display("FAIL dma_rd_return: rvld=%b data=%h gnt=%b want 1 77 0", dma_rvld, dma_rdata, dma_gnt); end
    @(negedge clk); #1;
    n_checks++; if (dma_rvld !== 1'b0) begin n_fail++; $display("FAIL dma_rvld_pulse: got %b want 0", dma_rvld); end
    @(negedge clk);
  endtask

  // CPU reads every cycle while DMA keeps requesting; grants expected on cycles 5 and 10.
  task automatic test_starvation();
    int a = 0;
    bit prev_rd = 0;
    int prev_a = 0;
    for (int i = 0; i < 9; i++) preload(16'h0100 + 16'(i), 8'hC0 + 8'(i));
    for (int c = 1; c <= 11; c++) begin
      bit exp_gnt, exp_pend;
      logic [15:0] exp_addr;
      dma_req = (c <= 10); dma_we = 1; dma_addr = 16'h0040; dma_wdata = (c <= 5) ? 8'h5A : 8'h5B;
      cpu_rd_en = 1; cpu_rd_addr = 16'h0100 + 16'(a);
      #1;
      exp_gnt  = (c == 5) || (c == 10);
      exp_pend = (c == 6) || (c == 11);
      exp_addr = exp_gnt ? 16'h0040 : 16'h0100 + 16'(a);
      n_checks++; if ({dma_gnt, cpu_rd_vld, mem_addr} !== {exp_gnt, !exp_pend, exp_addr}) begin
        n_fail++; $display("FAIL starve_c%0d: gnt=%b vld=%b addr=%h want %b %b %h",
                           c, dma_gnt, cpu_rd_vld, mem_addr, exp_gnt, !exp_pend, exp_addr); end
      if (prev_rd) begin
        n_checks++; if (cpu_rd_byte !== 8'hC0 + 8'(prev_a)) begin
          n_fail++; $display("FAIL starve_data_c%0d: got %h want %h", c, cpu_rd_byte, 8'hC0 + 8'(prev_a)); end
      end
      prev_rd = !exp_gnt; prev_a = a;
      if (!exp_gnt) a++;
      @(negedge clk);
    end
    idle_inputs();
    #1;
    n_checks++; if ({cpu_rd_vld, cpu_rd_byte} !== {1'b1, 8'hC8}) begin
      n_fail++; $display("FAIL starve_last: vld=%b byte=%h want 1 c8", cpu_rd_vld, cpu_rd_byte); end
    n_checks++; if (tb_mem[9'h040] !== 8'h5B) begin n_fail++; $display("FAIL starve_dma_wr: got %h want 5b", tb_mem[9'h040]); end
    @(negedge clk);
  endtask

  task automatic test_dma_write_protect();
    preload(16'h007F, 8'hEE);
    dma_req = 1; dma_we = 1; dma_addr = 16'h007F; dma_wdata = 8'h01;
    #1;
`ifdef XDATA_WR_PROTECT_EN
    n_checks++; if ({dma_gnt, mem_en, mem_we} !== 3'b100) begin
      n_fail++; $display("FAIL prot_issue: gnt=%b en=%b we=%b want 1 0 0", dma_gnt, mem_en, mem_we); end
`else
    n_checks++; if ({dma_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h007F, 8'h01}) begin
      n_fail++; $display("FAIL prot_issue: gnt=%b en=%b we=%b addr=%h wd=%h want 1 1 1 007f 01",
                         dma_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
`endif
    @(negedge clk); idle_inputs();
    cpu_wr_en = 1; cpu_wr_addr = 16'h007E; cpu_wr_byte = 8'h33;
    #1;
    n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 16'h007E}) begin
      n_fail++; $display("FAIL prot_cpu_wr: en=%b we=%b addr=%h want 1 1 007e", mem_en, mem_we, mem_addr); end
`ifdef XDATA_WR_PROTECT_EN
    n_checks++; if (dma_err !== 1'b1) begin n_fail++; $display("FAIL prot_err: got %b want 1", dma_err); end
`else
    n_checks++; if (dma_err !== 1'b0) begin n_fail++; $display("FAIL prot_err: got %b want 0", dma_err); end
`endif
    @(negedge clk); idle_inputs(); #1;
`ifdef XDATA_WR_PROTECT_EN
    n_checks++; if ({tb_mem[9'h07F], dma_err} !== {8'hEE, 1'b1}) begin
      n_fail++; $display("FAIL prot_mem: mem=%h err=%b want ee 1", tb_mem[9'h07F], dma_err); end
`else
    n_checks++; if (tb_mem[9'h07F] !== 8'h01) begin n_fail++; $display("FAIL prot_mem: got %h want 01", tb_mem[9'h07F]); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_pending();
    cpu_wr_en = 1; cpu_wr_addr = 16'h0030; cpu_wr_byte = 8'h44;
    cpu_rd_en = 1; cpu_rd_addr = 16'h0030;
    @(negedge clk); cpu_wr_en = 0;
    #1;
    n_checks++; if (cpu_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rstp_pending: vld=%b want 0", cpu_rd_vld); end
    #2; rst_n = 1'b0;
    #1;
    n_checks++; if ({cpu_rd_vld, mem_en, mem_we, dma_gnt, dma_rvld, dma_err, cpu_rd_byte} !== {6'b100000, 8'h00}) begin
      n_fail++; $display("FAIL rstp_outputs: vld=%b en=%b we=%b gnt=%b rvld=%b err=%b byte=%h want 1 0 0 0 0 0 00",
                         cpu_rd_vld, mem_en, mem_we, dma_gnt, dma_rvld, dma_err, cpu_rd_byte); end
    @(negedge clk); idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({cpu_rd_vld, dma_rvld, mem_en} !== 3'b100) begin
        n_fail++; $display("FAIL rstp_after%0d: vld=%b rvld=%b en=%b want 1 0 0", i, cpu_rd_vld, dma_rvld, mem_en); end
      @(negedge clk);
    end
    // DMA read granted, then reset lands before its return.
    dma_req = 1; dma_we = 0; dma_addr = 16'h0005;
    #1;
    n_checks++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rstd_gnt: got %b want 1", dma_gnt); end
    #2; rst_n = 1'b0; dma_req = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if ({dma_rvld, dma_rdata} !== {1'b0, 8'h00}) begin
        n_fail++; $display("FAIL rstd_after%0d: rvld=%b data=%h want 0 00", i, dma_rvld, dma_rdata); end
      @(negedge clk);
    end
  endtask

  // Randomized traffic against a reference of the priority rules and a shadow copy of the RAM.
  task automatic test_random();
    logic [7:0]  shadow [0:31];
    bit          m_pend = 0, dma_busy = 0;
    logic [15:0] m_paddr = '0;
    int          m_starve = 0;
    int          m_owner = 0;   // 0 none, 1 cpu, 2 dma
    logic [7:0]  m_ret = '0, m_hold = 8'h00;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      shadow[i] = d;
      preload(16'(i), d);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit rd_want, e_en, e_we, e_vld;
      int win;
      logic [15:0] raddr, e_addr;
      logic [7:0]  e_wd, e_byte;
      cpu_wr_en   = m_pend ? 1'b0 : ($urandom_range(0, 3) == 0);
      cpu_wr_addr = 16'($urandom_range(0, 31));
      cpu_wr_byte = 8'($urandom);
      cpu_rd_en   = ($urandom_range(0, 4) < 2);
      cpu_rd_addr = 16'($urandom_range(0, 31));
      if (!dma_busy && $urandom_range(0, 2) == 0) begin
        dma_busy = 1; dma_we = $urandom_range(0, 1) == 1;
        dma_addr = 16'($urandom_range(0, 31)); dma_wdata = 8'($urandom);
      end
      dma_req = dma_busy;
      #1;
      rd_want = m_pend || cpu_rd_en;
      raddr   = m_pend ? m_paddr : cpu_rd_addr;
      if (cpu_wr_en) win = 1;
      else if (rd_want && !(dma_req && m_starve == STARVE_MAX)) win = 2;
      else if (dma_req) win = 3;
      else win = 0;
      e_en   = (win != 0);
      e_we   = (win == 1) || (win == 3 && dma_we);
      e_addr = (win == 1) ? cpu_wr_addr : (win == 2) ? raddr : (win == 3) ? dma_addr : 16'h0000;
      e_wd   = (win == 1) ? cpu_wr_byte : dma_wdata;
      e_vld  = !m_pend;
      n_checks++; if ({mem_en, mem_we, dma_gnt, cpu_rd_vld} !== {e_en, e_we, win == 3, e_vld}) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: en=%b we=%b gnt=%b vld=%b want %b %b %b %b",
                           cyc, mem_en, mem_we, dma_gnt, cpu_rd_vld, e_en, e_we, win == 3, e_vld); end
      if (e_en) begin
        n_checks++; if (mem_addr !== e_addr) begin
          n_fail++; $display("FAIL rand_addr@%0d: got %h want %h", cyc, mem_addr, e_addr); end
      end
      if (e_we) begin
        n_checks++; if (mem_wdata !== e_wd) begin
          n_fail++; $display("FAIL rand_wdata@%0d: got %h want %h", cyc, mem_wdata, e_wd); end
      end
      if (m_owner == 1) m_hold = m_ret;
      e_byte = m_hold;
      n_checks++; if ({cpu_rd_byte, dma_rvld} !== {e_byte, m_owner == 2}) begin
        n_fail++; $display("FAIL rand_ret@%0d: byte=%h rvld=%b want %h %b", cyc, cpu_rd_byte, dma_rvld, e_byte, m_owner == 2); end
      if (m_owner == 2) begin
        n_checks++; if (dma_rdata !== m_ret) begin
          n_fail++; $display("FAIL rand_dma_data@%0d: got %h want %h", cyc, dma_rdata, m_ret); end
      end
      m_owner = 0;
      case (win)
        1: shadow[cpu_wr_addr[4:0]] = cpu_wr_byte;
        2: begin m_ret = shadow[raddr[4:0]]; m_owner = 1; end
        3: if (dma_we) shadow[dma_addr[4:0]] = dma_wdata;
           else begin m_ret = shadow[dma_addr[4:0]]; m_owner = 2; end
        default: ;
      endcase
      if (rd_want && win != 2) begin
        if (!m_pend) m_paddr = cpu_rd_addr;
        m_pend = 1;
      end else m_pend = 0;
      if (dma_req && win != 3) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else m_starve = 0;
      if (win == 3) dma_busy = 0;
      @(negedge clk);
    end
    idle_inputs(); #1;
    n_checks++; if (dma_err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", dma_err); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_wr_rd_collision();
    test_dma_read();
    test_starvation();
    test_dma_write_protect();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xdata_arbiter.md
Name: xdata_arbiter

Overview:
- Shares one single-port synchronous xdata RAM between the r8051 CPU xdata port and a secondary byte-wide requester (DMA/logger), which samples live DME state into xdata.
- Issues at most one memory access per cycle.
- Steers read data back to its owner and stalls CPU reads through the r8051 ram_rd_vld input when needed.
- Sits between u_cpu (ram_*_xdata signals) and the xdata memory macro.

Parameters:
- ADDR_W, 16, address width of all address ports.
- STARVE_MAX, 4, consecutive denied DMA request cycles after which DMA outranks a CPU read; legal range 1..15.
- PROT_BASE, 16'h0070, lowest DMA-write-protected address; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_rd_en  in  1  CPU xdata read strobe (ram_rd_en_xdata)
- cpu_rd_addr  in  ADDR_W  CPU read address
- cpu_wr_en  in  1  CPU xdata write strobe (ram_wr_en_xdata)
- cpu_wr_addr  in  ADDR_W  CPU write address
- cpu_wr_byte  in  8  CPU write data
- cpu_rd_byte  out  8  CPU read data
- cpu_rd_vld  out  1  drives r8051 ram_rd_vld; low = CPU read stalled
- dma_req  in  1  DMA access request, held until dma_gnt
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  8  DMA write data
- dma_gnt  out  1  1-cycle pulse: access issued this cycle
- dma_rdata  out  8  DMA read data
- dma_rvld  out  1  1-cycle pulse: dma_rdata valid
- dma_err  out  1  sticky protection violation flag
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid the cycle after mem_en & !mem_we

Behaviour:
- Reset values (rst_n low, asynchronous):
  - mem_en = mem_we = dma_gnt = dma_rvld = dma_err = 0
  - cpu_rd_vld = 1
  - cpu_rd_byte = dma_rdata = 8'h00
  - starve counter = 0
  - rd_owner = NONE
  - state = IDLE
- States:
  - IDLE: no CPU read deferred.
  - CPU_PEND: one CPU read captured in pend_addr, not yet issued.
- Per-cycle priority, one winner:
  1. CPU write
  2. CPU read (pending or new)
  3. DMA
  - Exception: when starve counter == STARVE_MAX, DMA beats a CPU read. It never beats a CPU write.
- Combinational decode: mem_en/mem_we/mem_addr/mem_wdata and dma_gnt are all decided in the same cycle.
- CPU write: mem_we = 1 the same cycle; never delayed.
- CPU read in IDLE:
  - If it wins, the read is issued the same cycle.
  - If it loses (same-cycle CPU write, or starved DMA), the address is captured and state goes to CPU_PEND.
- CPU_PEND:
  - cpu_rd_vld = 0 every cycle.
  - cpu_rd_en is ignored; the CPU is stalled and holds it.
  - The pending read issues at the first cycle it wins, then state returns to IDLE.
- Read return (rd_owner register, set on each issued read, NONE otherwise):
  - Owner CPU, next cycle: cpu_rd_byte = mem_rdata, cpu_rd_vld = 1, value held afterwards.
  - Owner DMA, next cycle: dma_rdata = mem_rdata registered, dma_rvld pulses.
  - Effective latency: CPU = 1 cycle undeferred, 1 + deferral cycles otherwise; DMA = 1 cycle after dma_gnt.
- Starve counter:
  - Increments each cycle dma_req = 1 and dma_gnt = 0, saturating at STARVE_MAX.
  - Clears on dma_gnt or when dma_req = 0.
- dma_gnt with dma_req low: never.
- DMA request changing before grant: undefined; not checked.
- Reset mid-operation: a pending CPU read and an in-flight return are discarded; no pulse after reset release.

Optional Feature:
- Macro: XDATA_WR_PROTECT_EN
- Defined:
  - DMA write with dma_addr >= PROT_BASE is granted normally (dma_gnt pulses), but mem_en and mem_we stay 0 that cycle.
  - dma_err sets the next cycle and stays 1 until reset.
  - CPU writes are never filtered.
- Undefined: every DMA write is performed and dma_err is tied 0.

Test Plan:
- Isolated CPU read of 0x0010 holding 8'hA5 -> mem_en the same cycle; cpu_rd_byte = 8'hA5 next cycle; cpu_rd_vld stays 1 throughout.
- Same-cycle CPU write 0x0020 = 8'h3C and CPU read 0x0020 -> write issued cycle N; read issued N+1; cpu_rd_vld = 0 at N+1; cpu_rd_byte = 8'h3C with cpu_rd_vld = 1 at N+2.
- dma_req held while CPU reads every cycle, STARVE_MAX = 4 -> dma_gnt on the 5th request cycle; the CPU read that cycle is deferred one cycle; counter returns to 0.
- DMA read 0x0005 holding 8'h77 with CPU idle -> dma_gnt the same cycle; dma_rvld pulse with dma_rdata = 8'h77 next cycle.
- With XDATA_WR_PROTECT_EN, DMA write 0x007F = 8'h01 -> dma_gnt = 1, mem_we = 0, dma_err = 1 next cycle; location unchanged. Without the macro -> written, dma_err = 0.
- rst_n asserted while in CPU_PEND -> all outputs return to reset values immediately; no cpu_rd_vld low and no dma_rvld pulse after release.
